// File: rtl/uart_defs.sv
// Constants shared by the UART receiver and its rx_fifo so both agree on word
// width and oversampling.
package uart_defs;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;  // baud ticks per bit period
  localparam int SB_TICK    = 16;  // ticks spent in one stop bit
endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, status-flag and sticky-overrun bookkeeping for rx_fifo.
// The storage array itself lives in the parent.
module fifo_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_tick,
  input  logic                  rd,
  input  logic                  clr_overrun,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overrun
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  wr_acc, rd_acc, drop;

  assign empty       = (level_q == '0);
  assign full        = (level_q == DEPTH_L);
  assign almost_full = (level_q >= AFULL_L);

  always_comb begin
    // A pop on a full FIFO frees the slot the write lands in, so both proceed.
    rd_acc    = rd && !empty;
    wr_acc    = wr_tick && (!full || rd);
    drop      = wr_tick && full && !rd;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc)      level_d = level_q + LVL_ONE;
    else if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  assign we      = wr_acc && !reset;
  assign waddr   = wr_ptr_q;
  assign raddr   = rd_ptr_q;
  assign level   = level_q;
  assign overrun = overrun_q;
endmodule

// File: rtl/rx_fifo.sv
// Receive byte buffer behind the UART receiver: register-array storage with a
// first-word fall-through read port that shows 0 while empty.
module rx_fifo
  import uart_defs::*;
#(
  parameter int DATA_BITS_P = DATA_BITS,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_tick,
  input  logic [DATA_BITS_P-1:0] wr_data,
  input  logic                   rd,
  output logic [DATA_BITS_P-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [ADDR_WIDTH:0]    level,
  output logic                   overrun,
  input  logic                   clr_overrun
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_BITS_P-1:0] mem_q [DEPTH];
  logic                   we;
  logic [ADDR_WIDTH-1:0]  waddr, raddr;

  fifo_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .AFULL_LEVEL(AFULL_LEVEL)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .wr_tick     (wr_tick),
    .rd          (rd),
    .clr_overrun (clr_overrun),
    .we          (we),
    .waddr       (waddr),
    .raddr       (raddr),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overrun     (overrun)
  );

  // Storage is deliberately left uninitialised on reset; empty gates the output.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[raddr];
endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: a constant-expectation vector table for the basics, then
// multi-cycle sequences checked against a queue scoreboard.
module tb_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, wr_tick, rd, clr_overrun;
  logic [7:0] wr_data, rd_data;
  logic       empty, full, almost_full, overrun;
  logic [4:0] level;

  int   n_vec = 0;
  int   n_bad = 0;
  logic [7:0] sb_q [$];
  logic       m_ovr = 1'b0;

  rx_fifo dut (
    .clk(clk), .reset(reset), .wr_tick(wr_tick), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
    .level(level), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wr;
    logic [7:0] d;
    logic       rd, clr;
    logic [7:0] e_data;
    int         e_level;
    logic       e_empty, e_full, e_afull, e_ovr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard/model update for one edge, from the pre-edge state.
  task automatic model_edge(input logic r, input logic w, input logic [7:0] d,
                            input logic p, input logic c);
    int  sz;
    logic mfull, mempty;
    sz = sb_q.size();
    mfull = (sz == 16);
    mempty = (sz == 0);
    if (r) begin
      sb_q.delete();
      m_ovr = 1'b0;
    end else begin
      if (p && !mempty) void'(sb_q.pop_front());
      if (w && (!mfull || p)) sb_q.push_back(d);
      if (w && mfull && !p) m_ovr = 1'b1;
      else if (c) m_ovr = 1'b0;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = sb_q.size();
    chk("rd_data", int'(rd_data), (sz == 0) ? 0 : int'(sb_q[0]));
    chk("level", int'(level), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == 16));
    chk("almost_full", int'(almost_full), int'(sz >= 12));
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic p, input logic c);
    reset = r; wr_tick = w; wr_data = d; rd = p; clr_overrun = c;
    @(posedge clk);
    model_edge(r, w, d, p, c);
    #1;
    check_model();
  endtask

  vec_t tbl [9];

  initial begin
    int writes, data, guard;
    reset = 1'b1; wr_tick = 1'b0; wr_data = '0; rd = 1'b0; clr_overrun = 1'b0;
    //          rst  wr   d      rd   clr  data   lvl e    f    af   ov
    tbl[0] = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00, 0,1'b1,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00, 0,1'b1,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 0,1'b1,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b0,1'b1,8'hA5,1'b0,1'b0,8'hA5, 1,1'b0,1'b0,1'b0,1'b0};
    tbl[4] = '{1'b0,1'b1,8'h3C,1'b0,1'b0,8'hA5, 2,1'b0,1'b0,1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h3C, 1,1'b0,1'b0,1'b0,1'b0};
    tbl[6] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 0,1'b1,1'b0,1'b0,1'b0};
    tbl[7] = '{1'b0,1'b1,8'h11,1'b1,1'b0,8'h11, 1,1'b0,1'b0,1'b0,1'b0};
    tbl[8] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00, 0,1'b1,1'b0,1'b0,1'b0};

    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; wr_tick = tbl[i].wr; wr_data = tbl[i].d;
      rd = tbl[i].rd; clr_overrun = tbl[i].clr;
      @(posedge clk);
      model_edge(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
      #1;
      chk($sformatf("tbl%0d.rd_data", i), int'(rd_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d.level", i), int'(level), tbl[i].e_level);
      chk($sformatf("tbl%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.full", i), int'(full), int'(tbl[i].e_full));
      chk($sformatf("tbl%0d.afull", i), int'(almost_full), int'(tbl[i].e_afull));
      chk($sformatf("tbl%0d.overrun", i), int'(overrun), int'(tbl[i].e_ovr));
    end

    // Fill 0x00..0x0F, almost_full edge at the 12th write, then overflow.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) chk("afull_before_12", int'(almost_full), 0);
      if (i == 11) chk("afull_at_12", int'(almost_full), 1);
    end
    chk("full_after_16", int'(full), 1);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("overrun_on_drop", int'(overrun), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("overrun_sticky_after_pops", int'(overrun), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("overrun_cleared", int'(overrun), 0);

    // Full FIFO with simultaneous pop and write.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw_level", int'(level), 16);
    chk("full_rw_overrun", int'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("last_pop_is_77", int'(rd_data), 8'h77);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Wrap-around: 40 writes interleaved with pops, level kept within 0..5.
    writes = 0; data = 8'h80; guard = 0;
    while (writes < 40 && guard < 1000) begin
      logic w, p;
      w = (sb_q.size() < 5) && ($urandom_range(1, 0) == 1);
      p = (sb_q.size() > 0) && ($urandom_range(1, 0) == 1);
      step(1'b0, w, 8'(data), p, 1'b0);
      if (w) begin writes++; data++; end
      guard++;
    end
    chk("wrap_writes_done", writes, 40);
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    chk("wrap_drained", int'(empty), 1);

    // Overrun set/clear, set beats clear, reset mid-operation.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovr_set", int'(overrun), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr", int'(overrun), 0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("ovr_set_wins", int'(overrun), 1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("level_7", int'(level), 7);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("reset_level", int'(level), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_ovr", int'(overrun), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
